divider_nbit_seq: RTL and testbench
===================================

# divider_nbit_seq

Sequential unsigned n-bit integer divider. It uses restoring division and resolves one quotient bit per clock. It is the inverse companion to the combinational n-bit multiplier and supplies the mantissa-quotient datapath for the fp32 divider. Operands are loaded with a start/busy/done handshake; quotient and remainder are held stable until the next accepted start.

## Interface
- WIDTH, 32, operand width in bits; WIDTH >= 2.
- IMPL_TYPE, 0, adder implementation selector; passed unchanged to every adder_nbit instance.

- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request to begin a division; sampled only when busy=0.
- A  input  WIDTH  dividend, unsigned; captured on the accepting edge.
- B  input  WIDTH  divisor, unsigned; captured on the accepting edge.
- busy  output  1  high while an iteration is in progress (RUN state).
- done  output  1  single-cycle pulse; Q/R/div_by_zero valid from this cycle on.
- Q  output  WIDTH  quotient, floor(A/B).
- R  output  WIDTH  remainder, A mod B.
- div_by_zero  output  1  high when the captured B was 0; valid with done.

## Operation
- States are IDLE, RUN and DONE, and all of them are registered. Reset enters IDLE.
- IDLE, start=1: capture A into the quotient/shift register and B into the divisor register. Clear the (WIDTH+1)-bit partial remainder. Register div_by_zero = (B==0). Load the bit counter with WIDTH. Go to RUN.
- RUN, each edge:
  - Shift the partial remainder left 1, bringing in the MSB of the shift register.
  - Compute trial = shifted remainder + two's complement of {1'b0,B}, using adder_nbit of width WIDTH+1.
  - If the trial MSB is 0, keep the trial and shift in quotient bit 1.
  - Otherwise keep the shifted remainder and shift in quotient bit 0.
  - Decrement the counter. On the edge where the counter reaches 0, go to DONE.
- DONE: done=1 for exactly this one cycle. Next edge goes to IDLE, or to RUN if start=1, which captures new operands (back-to-back accept).
- Start is ignored in RUN. Operand changes after the accepting edge have no effect.
- The two's complement of the divisor is formed once at capture, as ~{1'b0,B} + 1 through an adder_nbit. The iteration datapath uses no native +/- operators. The counter may use native arithmetic.
- Divide by zero takes the normal iteration path with no special case. Result: Q = all ones, R = A, div_by_zero = 1.
- Q and R are driven from the final registers and hold their values until the next accepted start overwrites them. During RUN they show intermediate values and are not meaningful.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, Q=0, R=0, div_by_zero=0, and all internal registers are 0. This applies immediately, including mid-RUN. The in-flight division is discarded and no done is produced.
- Latency: if start is accepted at edge E0, busy=1 from after E0 through edge E0+WIDTH. done=1 in the cycle after edge E0+WIDTH, so the accept edge to done is WIDTH cycles. done drops at edge E0+WIDTH+1.
- Throughput: one division per WIDTH+1 cycles with back-to-back starts. This is WIDTH+2 cycles if the engine returns through IDLE.
- busy and done are never both 1.
- The result is not a function of IMPL_TYPE; only the adder structure changes.

## Test plan
- WIDTH=32, A=100, B=7, start for one cycle -> done exactly 32 cycles after the accept edge; Q=14, R=2, div_by_zero=0; values held 10 cycles later.
- A=0xFFFFFFFF, B=1 -> Q=0xFFFFFFFF, R=0. Then A=5, B=9 -> Q=0, R=5.
- A=0x12345678, B=0 -> Q=0xFFFFFFFF, R=0x12345678, div_by_zero=1, done after 32 cycles.
- Hold start high with changing A/B during RUN -> the result matches only the operands captured at the first accept; in DONE, start with A=81, B=9 is accepted at once and gives Q=9, R=0.
- Pull rst_n low at cycle 10 of RUN, then release and start A=1000, B=33 -> all outputs 0 during reset, no stray done, then Q=30, R=10.
- Random 10k unsigned pairs with B≠0, for WIDTH=8 and WIDTH=32 and for each IMPL_TYPE -> Q*B+R==A and R<B for every result.

Source files
------------

// File: rtl/divider_nbit_seq.sv
// divider_nbit_seq: restoring unsigned divider, one quotient bit per clock, start/busy/done handshake.
module adder_nbit #(
  parameter int WIDTH = 8,
  parameter int IMPL_TYPE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);
  if (IMPL_TYPE == 0) begin : g_rca
    logic [WIDTH-1:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign sum[i] = a[i] ^ b[i] ^ c[i];
      if (i < WIDTH - 1) begin : g_c
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
    end
  end else begin : g_beh
    assign sum = a + b + {{(WIDTH-1){1'b0}}, cin};
  end
endmodule

module divider_nbit_seq #(
  parameter int WIDTH = 32,
  parameter int IMPL_TYPE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d, sq_q, sq_d;
  logic [WIDTH:0]   negb_q, negb_d, negb_new, shifted, trial;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d, accept;
  adder_nbit #(.WIDTH(WIDTH + 1), .IMPL_TYPE(IMPL_TYPE)) u_neg (
    .a(~{1'b0, B}), .b('0), .cin(1'b1), .sum(negb_new)
  );
  assign shifted = {rem_q, sq_q[WIDTH-1]};
  adder_nbit #(.WIDTH(WIDTH + 1), .IMPL_TYPE(IMPL_TYPE)) u_trial (
    .a(shifted), .b(negb_q), .cin(1'b0), .sum(trial)
  );
  assign accept = start && state_q != RUN;
  // The kept remainder is always below the divisor, so W bits hold it; bit W of the shift only feeds the trial.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sq_d    = sq_q;
    negb_d  = negb_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    if (accept) begin
      state_d = RUN;
      rem_d   = '0;
      sq_d    = A;
      negb_d  = negb_new;
      cnt_d   = CW'(WIDTH);
      dbz_d   = B == '0;
    end else if (state_q == RUN) begin
      rem_d   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      sq_d    = {sq_q[WIDTH-2:0], ~trial[WIDTH]};
      cnt_d   = cnt_q - CW'(1);
      state_d = cnt_q == CW'(1) ? DONE : RUN;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      sq_q    <= '0;
      negb_q  <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sq_q    <= sq_d;
      negb_q  <= negb_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end
  assign busy        = state_q == RUN;
  assign done        = state_q == DONE;
  assign Q           = sq_q;
  assign R           = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_divider_nbit_seq.sv
// tb_divider_nbit_seq: directed and random checks of the sequential divider against plain arithmetic.
module tb_divider_nbit_seq;
  logic clk = 0, rst_n = 0;
  logic start = 0, start8 = 0;
  logic [31:0] a = 0, b = 0, q, r;
  logic [7:0]  a8 = 0, b8 = 0, q8, r8;
  logic busy, done, dbz, busy8, done8, dbz8;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  divider_nbit_seq #(.WIDTH(32), .IMPL_TYPE(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b),
    .busy(busy), .done(done), .Q(q), .R(r), .div_by_zero(dbz)
  );
  divider_nbit_seq #(.WIDTH(8), .IMPL_TYPE(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .Q(q8), .R(r8), .div_by_zero(dbz8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done32(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      chk("busy_done_excl", busy & done, 0);
    end while (!done && cyc < 200);
    if (!done) chk("done32_timeout", done, 1);
  endtask

  task automatic wait_done8(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done8 && cyc < 100);
    if (!done8) chk("done8_timeout", done8, 1);
  endtask

  task automatic run32(input logic [31:0] av, input logic [31:0] bv, input string tag);
    int cyc;
    a = av; b = bv; start = 1;
    @(posedge clk); #1;
    start = 0;
    chk({tag, "_busy"}, busy, 1);
    wait_done32(cyc);
    chk({tag, "_lat"}, cyc, 32);
    chk({tag, "_q"}, q, bv == 0 ? 32'hFFFF_FFFF : av / bv);
    chk({tag, "_r"}, r, bv == 0 ? av : av % bv);
    chk({tag, "_dbz"}, dbz, bv == 0);
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] bv);
    int cyc;
    a8 = av; b8 = bv; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    wait_done8(cyc);
    chk("w8_lat", cyc, 8);
    chk("w8_q", q8, bv == 0 ? 8'hFF : av / bv);
    chk("w8_r", r8, bv == 0 ? av : av % bv);
    chk("w8_dbz", dbz8, bv == 0);
  endtask

  initial begin
    int cyc;
    logic seen;
    logic [31:0] ra, rb;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_dbz", dbz, 0);
    rst_n = 1;
    @(posedge clk); #1;

    run32(100, 7, "d100_7");
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    repeat (9) @(posedge clk);
    #1;
    chk("hold_q", q, 14);
    chk("hold_r", r, 2);

    run32(32'hFFFF_FFFF, 1, "max_1");
    run32(5, 9, "d5_9");
    run32(32'h1234_5678, 0, "div0");

    a = 200; b = 6; start = 1;
    @(posedge clk); #1;
    cyc = 0;
    do begin
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      cyc++;
    end while (!done && cyc < 200);
    chk("held_lat", cyc, 32);
    chk("held_q", q, 33);
    chk("held_r", r, 2);
    a = 81; b = 9;
    @(posedge clk); #1;
    chk("b2b_busy", busy, 1);
    start = 0;
    wait_done32(cyc);
    chk("b2b_lat", cyc, 32);
    chk("b2b_q", q, 9);
    chk("b2b_r", r, 0);

    a = 50; b = 3; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_q", q, 0);
    chk("mid_rst_r", r, 0);
    chk("mid_rst_dbz", dbz, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= done | busy;
    end
    chk("no_stray_done", seen, 0);
    rst_n = 1;
    @(posedge clk); #1;
    run32(1000, 33, "d1000_33");

    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 0) rb = 1;
      run32(ra, rb, "rand32");
    end

    run8(8'd200, 8'd0);
    run8(8'd255, 8'd1);
    for (int i = 0; i < 400; i++)
      run8(8'($urandom), 8'($urandom_range(1, 255)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
